// File: rtl/bfp_pkg.sv
// ============================================================================
// Module      : bfp_pkg
// Description : Shared constants, sample type and field-extraction helper for
//               the block-floating-point decompressor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bfp_pkg;

  localparam int SAMPLE_W         = 16;
  localparam int SAMPLES_PER_BEAT = 4;
  localparam int EXP_HDR_W        = 8;
  localparam int RB_BEATS_DEFAULT = 6;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Pull a w-bit field whose MSB sits 'off' bits below bit 63, right-justified.
  // Bits that would lie below bit 0 read as zero; w==0 yields zero.
  function automatic logic [SAMPLE_W-1:0] bfp_field(input logic [63:0] data,
                                                    input logic [5:0]  off,
                                                    input logic [3:0]  w);
    return 16'((data << off) >> (7'd64 - {3'b000, w}));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bfp_decomp_lane.sv
// ============================================================================
// Module      : bfp_decomp_lane
// Description : One IQ lane: sign-extends a W-bit mantissa (stage 2), then
//               shifts it left by the shared exponent (stage 3). With
//               BFP_DECOMP_SAT_EN defined, an out-of-range exponent saturates
//               the lane instead of truncating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bfp_decomp_lane
  import bfp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] field,
  input  logic [3:0]          width,
  input  logic [3:0]          exp,
  output sample_t             sample
);

  logic [4:0]          w_sh;
  logic [SAMPLE_W-1:0] w_left;
  sample_t             w_sext;
  logic                w_oor;

  // Left-justify then arithmetic-shift back down; width 0 shifts everything
  // out, so a zero-width lane naturally produces zero.
  assign w_sh   = 5'd16 - {1'b0, width};
  assign w_left = field << w_sh;
  assign w_sext = $signed(w_left) >>> w_sh;
  assign w_oor  = (width != 4'd0) && ({1'b0, exp} > w_sh);

  sample_t r_sext;
  logic [3:0] r_exp;
  logic    r_oor;
  sample_t w_next;

  // Stage 2: register the sign-extended mantissa with its exponent and range flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sext <= '0;
      r_exp  <= '0;
      r_oor  <= 1'b0;
    end else begin
      r_sext <= w_sext;
      r_exp  <= exp;
      r_oor  <= w_oor;
    end
  end

  // Stage 3 combinational: scale by the exponent, optionally saturate
  always_comb begin
    w_next = r_sext <<< r_exp;
`ifdef BFP_DECOMP_SAT_EN
    if (r_oor) begin
      w_next = r_sext[SAMPLE_W-1] ? sample_t'(16'h8000) : sample_t'(16'h7FFF);
    end
`endif
  end

  // Stage 3: registered lane output
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= '0;
    end else begin
      sample <= w_next;
    end
  end

`ifndef BFP_DECOMP_SAT_EN
  // Range flag only steers saturation; the top reports the error separately.
  logic w_unused_oor;
  assign w_unused_oor = r_oor;
`endif

endmodule

`default_nettype wire

// File: rtl/bfp_decomp_exp.sv
// ============================================================================
// Module      : bfp_decomp_exp
// Description : Block-floating-point decompressor. Takes RBs of RB_BEATS
//               64-bit beats (shared exponent in beat 0), expands each of the
//               4 mantissas per beat to a 16-bit IQ sample. Fixed 3-cycle
//               latency, no backpressure.
//               Optional macro: BFP_DECOMP_SAT_EN (saturate out-of-range lanes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bfp_decomp_exp
  import bfp_pkg::*;
#(
  parameter int RB_BEATS = RB_BEATS_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] din_data,
  input  logic        din_valid,
  input  logic        din_sync,
  input  logic        din_last,
  input  logic [3:0]  ud_iq_width,
  output logic [63:0] dout_data,
  output logic [2:0]  dout_state,
  output logic        dout_valid,
  output logic        dout_sync,
  output logic        dout_last,
  output logic        dout_err
);

  // Beat index is 3 bits wide, so RB_BEATS must not exceed 8.
  localparam logic [2:0] C_LAST_BEAT = 3'(RB_BEATS - 1);

  logic [2:0] r_s0;
  logic [3:0] r_exp_hold;
  logic [3:0] r_w_hold;

  logic       w_first;
  logic [3:0] w_exp;
  logic [3:0] w_w;
  logic       w_err;

  // A state-0 beat uses its own header and the live width; later beats reuse
  // the values captured at state 0.
  assign w_first = (r_s0 == 3'd0);
  assign w_exp   = w_first ? din_data[59:56] : r_exp_hold;
  assign w_w     = w_first ? ud_iq_width     : r_w_hold;
  assign w_err   = (w_w != 4'd0) && ({1'b0, w_exp} > (5'd16 - {1'b0, w_w}));

  logic [SAMPLE_W-1:0] w_field [SAMPLES_PER_BEAT];

  generate
    for (genvar i = 0; i < SAMPLES_PER_BEAT; i++) begin : g_field
      logic [5:0] w_off;
      assign w_off      = (w_first ? 6'(EXP_HDR_W) : 6'd0) + 6'(i) * {2'b00, w_w};
      assign w_field[i] = bfp_field(din_data, w_off, w_w);
    end
  endgenerate

  // Input beat counter plus per-RB exponent/width capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0       <= 3'd0;
      r_exp_hold <= 4'd0;
      r_w_hold   <= 4'd0;
    end else if (din_valid) begin
      if (w_first) begin
        r_exp_hold <= din_data[59:56];
        r_w_hold   <= ud_iq_width;
      end
      if (din_last || (r_s0 == C_LAST_BEAT)) begin
        r_s0 <= 3'd0;
      end else begin
        r_s0 <= r_s0 + 3'd1;
      end
    end
  end

  logic                r1_valid, r1_sync, r1_last, r1_err;
  logic [2:0]          r1_state;
  logic [3:0]          r1_exp, r1_w;
  logic [SAMPLE_W-1:0] r1_field [SAMPLES_PER_BEAT];

  // Stage 1: extracted fields and per-beat context
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sync  <= 1'b0;
      r1_last  <= 1'b0;
      r1_err   <= 1'b0;
      r1_state <= 3'd0;
      r1_exp   <= 4'd0;
      r1_w     <= 4'd0;
      for (int k = 0; k < SAMPLES_PER_BEAT; k++) r1_field[k] <= '0;
    end else begin
      r1_valid <= din_valid;
      r1_sync  <= din_sync;
      r1_last  <= din_last;
      r1_err   <= w_err;
      r1_state <= r_s0;
      r1_exp   <= w_exp;
      r1_w     <= w_w;
      for (int k = 0; k < SAMPLES_PER_BEAT; k++) r1_field[k] <= w_field[k];
    end
  end

  logic       r2_valid, r2_sync, r2_last, r2_err;
  logic [2:0] r2_state;

  // Stages 2 and 3: sideband delay matching the lane pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid   <= 1'b0;
      r2_sync    <= 1'b0;
      r2_last    <= 1'b0;
      r2_err     <= 1'b0;
      r2_state   <= 3'd0;
      dout_valid <= 1'b0;
      dout_sync  <= 1'b0;
      dout_last  <= 1'b0;
      dout_err   <= 1'b0;
      dout_state <= 3'd0;
    end else begin
      r2_valid   <= r1_valid;
      r2_sync    <= r1_sync;
      r2_last    <= r1_last;
      r2_err     <= r1_err;
      r2_state   <= r1_state;
      dout_valid <= r2_valid;
      dout_sync  <= r2_sync;
      dout_last  <= r2_last;
      dout_err   <= r2_err;
      dout_state <= r2_state;
    end
  end

  sample_t w_sample [SAMPLES_PER_BEAT];

  generate
    for (genvar i = 0; i < SAMPLES_PER_BEAT; i++) begin : g_lane
      bfp_decomp_lane u_lane (
        .clk    (clk),
        .rst    (rst),
        .field  (r1_field[i]),
        .width  (r1_w),
        .exp    (r1_exp),
        .sample (w_sample[i])
      );
      assign dout_data[63-SAMPLE_W*i -: SAMPLE_W] = w_sample[i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bfp_decomp_exp.sv
// ============================================================================
// Module      : tb_bfp_decomp_exp
// Description : Self-checking bench for bfp_decomp_exp. Table of hand-derived
//               single-beat RBs plus multi-beat sequences checked against a
//               bit-level reference model through a timed scoreboard.
//               Honours BFP_DECOMP_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bfp_decomp_exp;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] din_data;
  logic        din_valid, din_sync, din_last;
  logic [3:0]  ud_iq_width;
  logic [63:0] dout_data;
  logic [2:0]  dout_state;
  logic        dout_valid, dout_sync, dout_last, dout_err;

  always #5 clk = ~clk;

  bfp_decomp_exp #(.RB_BEATS(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .din_data    (din_data),
    .din_valid   (din_valid),
    .din_sync    (din_sync),
    .din_last    (din_last),
    .ud_iq_width (ud_iq_width),
    .dout_data   (dout_data),
    .dout_state  (dout_state),
    .dout_valid  (dout_valid),
    .dout_sync   (dout_sync),
    .dout_last   (dout_last),
    .dout_err    (dout_err)
  );

  typedef struct {
    logic [63:0] data;
    logic [2:0]  state;
    logic        err;
    logic        last;
    logic        sync;
    int          due;
  } exp_t;

  typedef struct {
    logic [3:0]       e;
    logic [3:0]       w;
    logic [3:0][14:0] m;
    bit               use_raw;
    logic [63:0]      raw;
    logic [63:0]      want;
    logic             want_err;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_on = 1'b0;

  int         m_s0 = 0;
  logic [3:0] m_exp = 4'd0;
  logic [3:0] m_w   = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit-by-bit reference: walk each lane's field, build a signed integer,
  // scale by 2^e and keep the low 16 bits.
  function automatic void model_beat(input logic [63:0] d, input bit first,
                                     input int w, input int e,
                                     output logic [63:0] o, output logic err);
    int start, pos, m, v;
    logic [15:0] r;
    err = (w != 0) && (e > 16 - w);
    o = '0;
    for (int ln = 0; ln < 4; ln++) begin
      start = 63 - (first ? 8 : 0) - ln * w;
      m = 0;
      for (int b = 0; b < w; b++) begin
        pos = start - b;
        m = m * 2 + ((pos >= 0 && d[pos]) ? 1 : 0);
      end
      v = (w > 0 && m >= (1 << (w - 1))) ? m - (1 << w) : m;
      r = 16'(v * (1 << e));
`ifdef BFP_DECOMP_SAT_EN
      if (err) r = (v >= 0) ? 16'h7FFF : 16'h8000;
`endif
      o[63-16*ln -: 16] = r;
    end
  endfunction

  function automatic logic [63:0] pack(input bit first, input logic [3:0] e,
                                       input int w, input logic [3:0][14:0] m);
    logic [63:0] d;
    int start, pos;
    d = '0;
    if (first) d[59:56] = e;
    for (int ln = 0; ln < 4; ln++) begin
      start = 63 - (first ? 8 : 0) - ln * w;
      for (int b = 0; b < w; b++) begin
        pos = start - b;
        if (pos >= 0) d[pos] = m[ln][w-1-b];
      end
    end
    return d;
  endfunction

  function automatic vec_t mk(input logic [3:0] e, input logic [3:0] w,
                              input logic [14:0] m0, input logic [14:0] m1,
                              input logic [14:0] m2, input logic [14:0] m3,
                              input logic [63:0] want, input logic want_err);
    vec_t v;
    v.e = e; v.w = w;
    v.m[0] = m0; v.m[1] = m1; v.m[2] = m2; v.m[3] = m3;
    v.use_raw = 1'b0; v.raw = '0;
    v.want = want; v.want_err = want_err;
    return v;
  endfunction

  // Drive one beat; expectation comes from the table when use_tbl, else the model.
  task automatic send(input logic [63:0] data, input logic [3:0] w_in,
                      input bit last, input bit sync,
                      input bit use_tbl, input logic [63:0] t_data, input logic t_err);
    exp_t x;
    logic [63:0] o;
    logic err;
    bit first;
    @(negedge clk); #1;
    first = (m_s0 == 0);
    if (first) begin
      m_exp = data[59:56];
      m_w   = w_in;
    end
    model_beat(data, first, int'(m_w), int'(m_exp), o, err);
    x.data  = use_tbl ? t_data : o;
    x.err   = use_tbl ? t_err  : err;
    x.state = 3'(m_s0);
    x.last  = last;
    x.sync  = sync;
    x.due   = cyc + 3;
    q.push_back(x);
    m_s0 = (last || m_s0 == 5) ? 0 : m_s0 + 1;
    din_data = data; din_valid = 1'b1; din_last = last; din_sync = sync;
    ud_iq_width = w_in;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      din_valid = 1'b0; din_last = 1'b0; din_sync = 1'b0;
      din_data = {$urandom, $urandom};
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst = 1'b1; din_valid = 1'b0; din_last = 1'b0;
    q.delete();
    m_s0 = 0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // Scoreboard: every cycle dout_valid must match whether a beat is due now
  always @(negedge clk) begin
    if (mon_on) begin
      exp_t e;
      bit   want_v;
      want_v = (q.size() > 0) && (q[0].due == cyc);
      chk("dout_valid", {63'd0, dout_valid}, {63'd0, want_v});
      if (want_v) begin
        e = q.pop_front();
        chk("dout_data",  dout_data, e.data);
        chk("dout_state", {61'd0, dout_state}, {61'd0, e.state});
        chk("dout_err",   {63'd0, dout_err},  {63'd0, e.err});
        chk("dout_last",  {63'd0, dout_last}, {63'd0, e.last});
        chk("dout_sync",  {63'd0, dout_sync}, {63'd0, e.sync});
      end else if (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("overdue beat", 64'd1, 64'd0);
      end
    end
  end

  vec_t tbl[8];
  logic [3:0][14:0] mm;

  initial begin
    rst = 1'b1; din_data = '0; din_valid = 1'b0; din_sync = 1'b0;
    din_last = 1'b0; ud_iq_width = 4'd0;

`ifdef BFP_DECOMP_SAT_EN
    tbl[1] = mk(4'd8, 4'd9, 15'h0FF, 15'h000, 15'h000, 15'h000, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1);
    tbl[2] = mk(4'd8, 4'd9, 15'h100, 15'h000, 15'h000, 15'h000, 64'h8000_7FFF_7FFF_7FFF, 1'b1);
    tbl[5] = mk(4'd13, 4'd4, 15'h1, 15'h8, 15'hF, 15'h0, 64'h7FFF_8000_8000_7FFF, 1'b1);
`else
    tbl[1] = mk(4'd8, 4'd9, 15'h0FF, 15'h000, 15'h000, 15'h000, 64'hFF00_0000_0000_0000, 1'b1);
    tbl[2] = mk(4'd8, 4'd9, 15'h100, 15'h000, 15'h000, 15'h000, 64'h0000_0000_0000_0000, 1'b1);
    tbl[5] = mk(4'd13, 4'd4, 15'h1, 15'h8, 15'hF, 15'h0, 64'h2000_0000_E000_0000, 1'b1);
`endif
    tbl[0] = mk(4'd3, 4'd9, 15'h0FF, 15'h100, 15'h000, 15'h001, 64'h07F8_F800_0000_0008, 1'b0);
    tbl[3] = mk(4'd15, 4'd0, 15'h0, 15'h0, 15'h0, 15'h0, 64'h0, 1'b0);
    tbl[3].use_raw = 1'b1;
    tbl[3].raw = 64'h0F12_3456_789A_BCDE;
    tbl[4] = mk(4'd12, 4'd4, 15'h7, 15'h8, 15'hF, 15'h1, 64'h7000_8000_F000_1000, 1'b0);
    tbl[6] = mk(4'd1, 4'd15, 15'h4000, 15'h3FFF, 15'h0001, 15'h7FFF, 64'h8000_7FFE_0002_FFE0, 1'b0);
    tbl[7] = mk(4'd15, 4'd1, 15'h1, 15'h0, 15'h1, 15'h0, 64'h8000_0000_8000_0000, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset dout_valid", {63'd0, dout_valid}, 64'd0);
    chk("reset dout_last",  {63'd0, dout_last},  64'd0);
    chk("reset dout_sync",  {63'd0, dout_sync},  64'd0);
    chk("reset dout_err",   {63'd0, dout_err},   64'd0);
    chk("reset dout_state", {61'd0, dout_state}, 64'd0);
    chk("reset dout_data",  dout_data,           64'd0);
    #1 rst = 1'b0;
    mon_on = 1'b1;

    // Single-beat RBs (din_last on each) from the hand-derived table
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].use_raw ? tbl[i].raw : pack(1'b1, tbl[i].e, int'(tbl[i].w), tbl[i].m),
           tbl[i].w, 1'b1, i[0], 1'b1, tbl[i].want, tbl[i].want_err);
    end
    idle(2);

    // Full RB with a gap, then a 7th beat that must decode as state 0
    mm[0] = 15'h0FF; mm[1] = 15'h100; mm[2] = 15'h000; mm[3] = 15'h001;
    send(pack(1'b1, 4'd3, 9, mm), 4'd9, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    mm[0] = 15'h1FF; mm[1] = 15'h1FF; mm[2] = 15'h1FF; mm[3] = 15'h1FF;
    for (int b = 1; b < 6; b++) begin
      if (b == 3) idle(1);
      send(pack(1'b0, 4'd0, 9, mm), 4'd9, 1'b0, 1'b0, 1'b1, 64'hFFF8_FFF8_FFF8_FFF8, 1'b0);
    end
    mm[0] = 15'h011; mm[1] = 15'h1F0; mm[2] = 15'h0AA; mm[3] = 15'h155;
    send(pack(1'b1, 4'd2, 9, mm), 4'd9, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(1);

    // Short RB: last on state 2, next beat carries a fresh exponent
    mm[0] = 15'h21; mm[1] = 15'h3F; mm[2] = 15'h05; mm[3] = 15'h10;
    send(pack(1'b1, 4'd3, 6, mm), 4'd6, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send({$urandom, $urandom}, 4'd6, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send({$urandom, $urandom}, 4'd6, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    send(pack(1'b1, 4'd5, 6, mm), 4'd6, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    send({$urandom, $urandom}, 4'd6, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(2);

    // Width change mid-RB is ignored; reset with a beat in flight
    mm[0] = 15'h0F0; mm[1] = 15'h00F; mm[2] = 15'h1AB; mm[3] = 15'h055;
    send(pack(1'b1, 4'd4, 9, mm), 4'd9, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send({$urandom, $urandom}, 4'd9, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send({$urandom, $urandom}, 4'd9, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send({$urandom, $urandom}, 4'd5, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send({$urandom, $urandom}, 4'd5, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    pulse_reset();
    send(pack(1'b1, 4'd2, 5, mm), 4'd5, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send({$urandom, $urandom}, 4'd5, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(2);

    // Random RBs with random widths, exponents, gaps and sync
    for (int r = 0; r < 4; r++) begin
      logic [63:0] d;
      logic [3:0]  w;
      w = 4'($urandom_range(0, 15));
      for (int b = 0; b < 6; b++) begin
        d = {$urandom, $urandom};
        if (b == 0) d[63:60] = 4'd0;
        if ($urandom_range(0, 3) == 0) idle(1);
        send(d, (b == 0) ? w : 4'($urandom_range(0, 15)), b == 5, $urandom_range(0, 1) == 1,
             1'b0, '0, 1'b0);
      end
    end
    idle(1);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
